// File: rtl/free_list.sv
// Physical-register free list: circular buffer of free tags with a speculative
// allocate head, a committed head for mispredict recovery, and a free tail.
module free_list #(
  parameter int PHY_REGS  = 64,
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   alloc_req,
  output logic [TAG_W-1:0]                       alloc_tag,
  output logic                                   alloc_valid,
  input  logic                                   commit_alloc,
  input  logic                                   free_req,
  input  logic [TAG_W-1:0]                       free_tag,
  input  logic                                   flush,
  output logic [$clog2(PHY_REGS-ARCH_REGS):0]    free_count,
  output logic                                   err
);
  localparam int CAP = PHY_REGS - ARCH_REGS;
  localparam int IW  = $clog2(CAP);
  localparam int PW  = IW + 1;

  logic [TAG_W-1:0] entries [CAP];
  logic [PW-1:0]    head, chead, tail;
  logic [PW-1:0]    head_nxt, chead_nxt, tail_nxt, count_nxt;
  logic             grant, commit_ok, free_ok, full, err_nxt;

  assign alloc_valid = (free_count != '0);
  assign alloc_tag   = entries[head[IW-1:0]];

  // Next-state: pointers wrap modulo 2*CAP through the extra wrap bit.
  always_comb begin
    full      = (free_count == PW'(CAP));
    commit_ok = commit_alloc && (chead != head);
    grant     = alloc_req && alloc_valid && !flush;
    free_ok   = free_req && !full;
    chead_nxt = chead + PW'(commit_ok);
    tail_nxt  = tail + PW'(free_ok);
    if (flush) begin
      // Everything between the committed head and the speculative head returns.
      head_nxt  = chead_nxt;
      count_nxt = free_count + (head - chead_nxt) + PW'(free_ok);
    end else begin
      head_nxt  = head + PW'(grant);
      count_nxt = free_count - PW'(grant) + PW'(free_ok);
    end
    err_nxt = err || (free_req && full) || (commit_alloc && !commit_ok);
  end

  // State update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CAP; i++) entries[i] <= TAG_W'(ARCH_REGS + i);
      head       <= '0;
      chead      <= '0;
      tail       <= '0;
      free_count <= PW'(CAP);
      err        <= 1'b0;
    end else begin
      if (free_ok) entries[tail[IW-1:0]] <= free_tag;
      head       <= head_nxt;
      chead      <= chead_nxt;
      tail       <= tail_nxt;
      free_count <= count_nxt;
      err        <= err_nxt;
    end
  end
endmodule

// File: tb/tb_free_list.sv
// Directed and scoreboarded checks of the free list: reset, allocation order,
// empty/full boundaries, flush recovery, error flag and wrapping random traffic.
module tb_free_list;
  logic       clk = 1'b0;
  logic       rst, alloc_req, commit_alloc, free_req, flush;
  logic [5:0] free_tag;
  logic [5:0] alloc_tag;
  logic       alloc_valid, err;
  logic [5:0] free_count;
  int         total = 0;
  int         passed = 0;

  free_list dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_tag(alloc_tag),
    .alloc_valid(alloc_valid), .commit_alloc(commit_alloc), .free_req(free_req),
    .free_tag(free_tag), .flush(flush), .free_count(free_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = 0; commit_alloc = 0; free_req = 0; flush = 0; free_tag = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; alloc_req = 1; free_req = 1; free_tag = 6'd9; commit_alloc = 1; flush = 1;
    tick();
    rst = 0; idle();
    total++; if (free_count !== 6'd32) $display("FAIL reset_count got %0d want 32", free_count); else passed++;
    total++; if (alloc_valid !== 1'b1) $display("FAIL reset_valid got %b want 1", alloc_valid); else passed++;
    total++; if (alloc_tag !== 6'd32) $display("FAIL reset_tag got %0d want 32", alloc_tag); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
  endtask

  task automatic test_alloc();
    do_reset();
    alloc_req = 1;
    for (int i = 0; i < 3; i++) begin
      total++; if (alloc_tag !== 6'(32 + i)) $display("FAIL alloc_tag%0d got %0d want %0d", i, alloc_tag, 32 + i); else passed++;
      tick();
      total++; if (free_count !== 6'(31 - i)) $display("FAIL alloc_count%0d got %0d want %0d", i, free_count, 31 - i); else passed++;
    end
    idle();
    total++; if (err !== 1'b0) $display("FAIL alloc_err got %b want 0", err); else passed++;
  endtask

  task automatic test_empty();
    do_reset();
    alloc_req = 1;
    for (int i = 0; i < 32; i++) tick();
    total++; if (free_count !== 6'd0) $display("FAIL empty_count got %0d want 0", free_count); else passed++;
    total++; if (alloc_valid !== 1'b0) $display("FAIL empty_valid got %b want 0", alloc_valid); else passed++;
    tick();
    total++; if (free_count !== 6'd0) $display("FAIL empty_ignore got %0d want 0", free_count); else passed++;
    free_req = 1; free_tag = 6'd5;
    tick();
    free_req = 0;
    total++; if (free_count !== 6'd1) $display("FAIL empty_free_count got %0d want 1", free_count); else passed++;
    total++; if (alloc_valid !== 1'b1) $display("FAIL empty_free_valid got %b want 1", alloc_valid); else passed++;
    total++; if (alloc_tag !== 6'd5) $display("FAIL empty_free_tag got %0d want 5", alloc_tag); else passed++;
    total++; if (err !== 1'b0) $display("FAIL empty_err got %b want 0", err); else passed++;
    tick();
    idle();
    total++; if (free_count !== 6'd0) $display("FAIL empty_regrant got %0d want 0", free_count); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 1;
    for (int i = 0; i < 4; i++) tick();
    idle();
    commit_alloc = 1; tick(); tick();
    idle();
    total++; if (alloc_tag !== 6'd36) $display("FAIL flush_pre_tag got %0d want 36", alloc_tag); else passed++;
    flush = 1; alloc_req = 1; tick();
    idle();
    total++; if (alloc_tag !== 6'd34) $display("FAIL flush_tag got %0d want 34", alloc_tag); else passed++;
    total++; if (free_count !== 6'd30) $display("FAIL flush_count got %0d want 30", free_count); else passed++;
    total++; if (err !== 1'b0) $display("FAIL flush_err got %b want 0", err); else passed++;
  endtask

  task automatic test_flush_combo();
    do_reset();
    alloc_req = 1;
    for (int i = 0; i < 3; i++) tick();
    idle();
    // count 29, head 3, chead' 1 -> 29 + 2 + 1
    flush = 1; commit_alloc = 1; free_req = 1; free_tag = 6'd7; alloc_req = 1;
    tick();
    idle();
    total++; if (free_count !== 6'd32) $display("FAIL combo_count got %0d want 32", free_count); else passed++;
    total++; if (alloc_tag !== 6'd33) $display("FAIL combo_tag got %0d want 33", alloc_tag); else passed++;
    total++; if (err !== 1'b0) $display("FAIL combo_err got %b want 0", err); else passed++;
    alloc_req = 1;
    for (int i = 0; i < 31; i++) tick();
    idle();
    total++; if (alloc_tag !== 6'd7) $display("FAIL combo_tail_tag got %0d want 7", alloc_tag); else passed++;
    total++; if (free_count !== 6'd1) $display("FAIL combo_tail_count got %0d want 1", free_count); else passed++;
  endtask

  task automatic test_err();
    do_reset();
    commit_alloc = 1; tick(); idle();
    total++; if (err !== 1'b1) $display("FAIL err_commit got %b want 1", err); else passed++;
    do_reset();
    free_req = 1; free_tag = 6'd9; tick(); idle();
    total++; if (err !== 1'b1) $display("FAIL err_full got %b want 1", err); else passed++;
    total++; if (free_count !== 6'd32) $display("FAIL err_full_count got %0d want 32", free_count); else passed++;
    total++; if (alloc_tag !== 6'd32) $display("FAIL err_full_tag got %0d want 32", alloc_tag); else passed++;
    commit_alloc = 1; tick(); idle();
    total++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else passed++;
    do_reset();
    total++; if (err !== 1'b0) $display("FAIL err_clear got %b want 0", err); else passed++;
  endtask

  task automatic test_random();
    int  fq[$], sq[$], pool[$];
    bit  issued[64];
    int  credit, idx, ft, t;
    bit  do_alloc, do_commit, do_free, do_flush;
    logic [5:0] seen;
    do_reset();
    for (int i = 0; i < 64; i++) issued[i] = (i < 32);
    for (int i = 0; i < 32; i++) begin pool.push_back(i); fq.push_back(32 + i); end
    credit = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      do_flush  = ($urandom_range(0, 15) == 0);
      do_alloc  = ($urandom_range(0, 3) != 0);
      do_commit = (sq.size() > 0) && ($urandom_range(0, 2) != 0);
      do_free   = (credit > 0) && ($urandom_range(0, 3) != 0);
      ft = 0;
      if (do_free) begin
        idx = $urandom_range(0, pool.size() - 1);
        ft = pool[idx];
        pool.delete(idx);
      end
      if (fq.size() > 0) begin
        total++; if (alloc_tag !== 6'(fq[0])) $display("FAIL rnd_tag c%0d got %0d want %0d", cyc, alloc_tag, fq[0]); else passed++;
      end else begin
        total++; if (alloc_valid !== 1'b0) $display("FAIL rnd_valid c%0d got %b want 0", cyc, alloc_valid); else passed++;
      end
      seen = alloc_tag;
      alloc_req = do_alloc; commit_alloc = do_commit; flush = do_flush;
      free_req = do_free; free_tag = 6'(ft);
      tick();
      if (do_commit) begin pool.push_back(sq.pop_front()); credit++; end
      if (do_flush) begin
        while (sq.size() > 0) begin t = sq.pop_back(); issued[t] = 0; fq.push_front(t); end
      end else if (do_alloc && fq.size() > 0) begin
        void'(fq.pop_front());
        total++; if (issued[seen]) $display("FAIL rnd_dup c%0d tag %0d issued twice", cyc, seen); else passed++;
        issued[seen] = 1;
        sq.push_back(int'(seen));
      end
      if (do_free) begin fq.push_back(ft); issued[ft] = 0; credit--; end
      total++; if (free_count !== 6'(fq.size())) $display("FAIL rnd_count c%0d got %0d want %0d", cyc, free_count, fq.size()); else passed++;
    end
    idle();
    total++; if (err !== 1'b0) $display("FAIL rnd_err got %b want 0", err); else passed++;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_empty();
    test_flush();
    test_flush_combo();
    test_err();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
